// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler that shares one serial double-dabble engine among NREQ requesters.
// Results come back as packed BCD digits tagged with the index of the requester that owns them.
module bcd_conv_sched #(
  parameter int W      = 16,
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*W-1:0]     bin_in,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic                  bcd_valid,
  output logic [IDW-1:0]        bcd_id,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r, state_next_s;
  logic [IDW-1:0]   ptr_r, grant_r, pick_s;
  logic             pick_ok_s;
  logic [W-1:0]     sr_r, sr_step_s;
  logic [AW-1:0]    acc_r, acc_adj_s, acc_step_s;
  logic [AW+W-1:0]  cat_s;
  logic [CW-1:0]    cnt_r;
  logic [NREQ-1:0]  ack_r;
  logic             busy_r, valid_r;
  logic [IDW-1:0]   id_r;
  logic [AW-1:0]    out_r;

  assign ack       = ack_r;
  assign busy      = busy_r;
  assign bcd_valid = valid_r;
  assign bcd_id    = id_r;
  assign bcd_out   = out_r;

  // Arbiter: first raised request at or after the round-robin pointer.
  always_comb begin
    logic hit_s;
    pick_ok_s = 1'b0;
    pick_s    = {IDW{1'b0}};
    hit_s     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      hit_s     = !pick_ok_s && req[(int'(ptr_r) + i) % NREQ];
      pick_s    = hit_s ? IDW'((int'(ptr_r) + i) % NREQ) : pick_s;
      pick_ok_s = pick_ok_s | hit_s;
    end
  end

  // One double-dabble step: add 3 to digits >= 5, then shift the binary MSB into the accumulator.
  always_comb begin
    acc_adj_s = acc_r;
    for (int d = 0; d < DIGITS; d++) begin
      acc_adj_s[4*d +: 4] = (acc_r[4*d +: 4] >= 4'd5) ? (acc_r[4*d +: 4] + 4'd3) : acc_r[4*d +: 4];
    end
    cat_s      = {acc_adj_s, sr_r} << 1;
    acc_step_s = cat_s[AW+W-1:W];
    sr_step_s  = cat_s[W-1:0];
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = pick_ok_s ? LOAD : IDLE;
      LOAD:    state_next_s = SHIFT;
      SHIFT:   state_next_s = (cnt_r == CW'(1)) ? DONE : SHIFT;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath and registered outputs; the operand is captured on the grant edge so ack marks it taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r   <= {IDW{1'b0}};
      grant_r <= {IDW{1'b0}};
      sr_r    <= {W{1'b0}};
      acc_r   <= {AW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      ack_r   <= {NREQ{1'b0}};
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      id_r    <= {IDW{1'b0}};
      out_r   <= {AW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_ok_s) begin
            grant_r <= pick_s;
            ack_r   <= {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
            busy_r  <= 1'b1;
            sr_r    <= bin_in[int'(pick_s)*W +: W];
          end else begin
            ack_r   <= {NREQ{1'b0}};
          end
        end
        LOAD: begin
          ack_r <= {NREQ{1'b0}};
          acc_r <= {AW{1'b0}};
          cnt_r <= CW'(W);
          ptr_r <= (int'(grant_r) == NREQ - 1) ? {IDW{1'b0}} : (grant_r + IDW'(1));
        end
        SHIFT: begin
          acc_r <= acc_step_s;
          sr_r  <= sr_step_s;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            valid_r <= 1'b1;
            out_r   <= acc_step_s;
            id_r    <= grant_r;
          end else begin
            valid_r <= 1'b0;
          end
        end
        DONE: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          ack_r   <= {NREQ{1'b0}};
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Self-checking bench: a transaction-level model predicts every output each cycle,
// and directed scenarios pin the model with hand-computed decimal results and service orders.
module tb_bcd_conv_sched;
  localparam int W = 16, NREQ = 4, IDW = 2, DIGITS = 5, AW = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] bin_in;
  logic [NREQ-1:0]   ack;
  logic              busy, bcd_valid;
  logic [IDW-1:0]    bcd_id;
  logic [AW-1:0]     bcd_out;

  bcd_conv_sched #(.W(W), .NREQ(NREQ), .IDW(IDW), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .req(req), .bin_in(bin_in), .ack(ack), .busy(busy),
    .bcd_valid(bcd_valid), .bcd_id(bcd_id), .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int got_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Decimal digits by plain division.
  function automatic logic [AW-1:0] to_bcd(int unsigned v);
    logic [AW-1:0] r;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Job-level model: a grant starts a job lasting W+2 cycles (ack, W shifts, result).
  bit               m_active;
  int               m_age, m_id, m_ptr;
  logic [W-1:0]     m_op;
  logic [NREQ-1:0]  exp_ack;
  logic             exp_busy, exp_valid;
  logic [IDW-1:0]   exp_id;
  logic [AW-1:0]    exp_out;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_age = 0; m_ptr = 0;
      exp_ack = '0; exp_busy = 1'b0; exp_valid = 1'b0; exp_id = '0; exp_out = '0;
    end else begin
      if (m_active) begin
        if (m_age == W + 2) m_active = 1'b0;
        else m_age++;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (!m_active && req[(m_ptr + i) % NREQ]) begin
            m_active = 1'b1;
            m_age    = 1;
            m_id     = (m_ptr + i) % NREQ;
            m_op     = bin_in[m_id*W +: W];
          end
        end
        if (m_active) m_ptr = (m_id + 1) % NREQ;
      end
      exp_ack   = (m_active && m_age == 1) ? (NREQ'(1) << m_id) : '0;
      exp_busy  = m_active;
      exp_valid = m_active && (m_age == W + 2);
      if (exp_valid) begin
        exp_out = to_bcd(int'(m_op));
        exp_id  = IDW'(m_id);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", ack, exp_ack);
      check("busy", busy, exp_busy);
      check("bcd_valid", bcd_valid, exp_valid);
      check("bcd_id", bcd_id, exp_id);
      check("bcd_out", bcd_out, exp_out);
      check("ack_onehot", ($countones(ack) <= 1), 1);
    end
  end

  task automatic set_op(int id, logic [W-1:0] v);
    bin_in[id*W +: W] = v;
  endtask

  task automatic reset_dut();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic wait_ack(int id, int lim, output int lat);
    lat = -1;
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      if (ack[id] && lat < 0) begin lat = c; break; end
    end
    if (lat < 0) check("ack_timeout", 0, 1);
  endtask

  task automatic wait_valid(int lim, output int lat, output logic [AW-1:0] o, output logic [IDW-1:0] i);
    lat = -1; o = '0; i = '0;
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      if (bcd_valid) begin lat = c; o = bcd_out; i = bcd_id; break; end
    end
    if (lat < 0) check("valid_timeout", 0, 1);
  endtask

  task automatic convert(int id, logic [W-1:0] v, logic [AW-1:0] exp_lit, bit change_op);
    int la, lv, base;
    logic [AW-1:0] o;
    logic [IDW-1:0] oid;
    @(negedge clk);
    set_op(id, v);
    req[id] = 1'b1;
    wait_ack(id, 4 * (W + 3), la);
    req[id] = 1'b0;
    base = 0;
    if (change_op) begin
      repeat (3) @(negedge clk);
      set_op(id, ~v);
      base = 3;
    end
    wait_valid(2 * W, lv, o, oid);
    check("ack_latency", la, 1);
    check("valid_latency", lv + base, W + 1);
    check("lit_bcd_out", o, exp_lit);
    check("lit_bcd_id", oid, id);
  endtask

  // Holds the masked requests until n acks are seen, logging the service order.
  task automatic grant_order(logic [NREQ-1:0] mask, int n, bit do_reset);
    int seen;
    if (do_reset) reset_dut();
    got_q.delete();
    for (int k = 0; k < NREQ; k++) set_op(k, 16'(1000 * k + 7 * k + 3));
    @(negedge clk);
    req = mask;
    seen = 0;
    for (int c = 0; c < n * (W + 3) + 20 && seen < n; c++) begin
      @(negedge clk);
      for (int k = 0; k < NREQ; k++) begin
        if (ack[k]) begin got_q.push_back(k); seen++; end
      end
      if (seen >= n) req = '0;
    end
    req = '0;
    check("order_len", got_q.size(), n);
    repeat (W + 4) @(negedge clk);
  endtask

  initial begin
    int saw;
    logic [W-1:0] v;
    rst = 1'b1; req = '0; bin_in = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", bcd_valid, 0);
    check("rst_out", bcd_out, 0);
    rst = 1'b0;

    convert(0, 16'd65535, 20'h65535, 1'b0);
    convert(1, 16'd0,     20'h00000, 1'b0);
    convert(1, 16'd9,     20'h00009, 1'b0);
    convert(1, 16'd10,    20'h00010, 1'b0);
    convert(1, 16'd9999,  20'h09999, 1'b0);
    convert(1, 16'd40960, 20'h40960, 1'b0);

    grant_order(4'b0101, 4, 1'b1);
    check("cont0", got_q[0], 0); check("cont1", got_q[1], 2);
    check("cont2", got_q[2], 0); check("cont3", got_q[3], 2);

    grant_order(4'b1111, 5, 1'b1);
    check("fair0", got_q[0], 0); check("fair1", got_q[1], 1); check("fair2", got_q[2], 2);
    check("fair3", got_q[3], 3); check("fair4", got_q[4], 0);

    // Reset during SHIFT discards the job and returns the pointer to 0.
    @(negedge clk);
    set_op(2, 16'd4321);
    req[2] = 1'b1;
    wait_ack(2, 2 * (W + 3), saw);
    req[2] = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", bcd_valid, 0);
    check("mid_rst_id", bcd_id, 0);
    check("mid_rst_out", bcd_out, 0);
    rst = 1'b0;
    saw = 0;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk);
      if (bcd_valid) saw++;
    end
    check("no_valid_after_rst", saw, 0);
    grant_order(4'b1001, 2, 1'b0);
    check("ptr0_first", got_q[0], 0);
    check("ptr0_second", got_q[1], 3);
    convert(3, 16'd1234, 20'h01234, 1'b0);

    convert(0, 16'd31337, 20'h31337, 1'b1);

    // Random requesters: hold until ack, sometimes re-request or withdraw.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(599, 0) == 0);
      for (int k = 0; k < NREQ; k++) begin
        if (req[k]) begin
          if (ack[k]) begin
            if ($urandom_range(1, 0) == 0) req[k] = 1'b0;
          end else if ($urandom_range(29, 0) == 0) begin
            req[k] = 1'b0;
          end
        end else if ($urandom_range(5, 0) == 0) begin
          case ($urandom_range(5, 0))
            0:       v = 16'd0;
            1:       v = 16'hFFFF;
            2:       v = 16'(9 + 10 * $urandom_range(1, 0));
            default: v = 16'($urandom);
          endcase
          set_op(k, v);
          req[k] = 1'b1;
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    repeat (W + 6) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
